// File: rtl/sky130_sram_ctrl_pkg.sv
// Shared definitions for the port-0 controller of the sky130 1rw1r OpenRAM macro.
//   ST_INIT / ST_RUN  : legacy state encodings, also backing the ctrl_state_e enum
//   BYTE_W            : width of one write-mask lane
//   lanes_match()     : elaboration-time width consistency helper
package sky130_sram_ctrl_pkg;

  localparam int BYTE_W = 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    INIT = ST_INIT,
    RUN  = ST_RUN
  } ctrl_state_e;

  function automatic bit lanes_match(input int num_wmasks, input int data_width);
    return data_width == BYTE_W * num_wmasks;
  endfunction

endpackage

// File: rtl/sky130_sram_rsp_fifo.sv
// Synchronous response FIFO holding read data until the consumer takes it.
//   clk, rst_n        : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   : write one entry (caller guarantees space)
//   pop               : remove head entry (caller guarantees non-empty)
//   pop_data          : head entry, valid while !empty
//   empty, count      : occupancy status; count feeds the upstream credit check
module sky130_sram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sky130_sram_port0_ctrl.sv
// Port-0 (RW) controller for the sky130 1rw1r OpenRAM macro.
// Converts a valid/ready request stream into registered macro pin activity and
// returns read data, in order, through a credit-limited response FIFO.
//   clk, rst_n                     : clock (also macro clk0), sync active-low reset
//   req_valid/req_ready            : request handshake
//   req_we/req_wmask/req_addr/req_wdata : request payload
//   rsp_valid/rsp_ready/rsp_rdata  : read response stream
//   init_done                      : high once the power-up sweep has finished
//   csb0/web0/wmask0/addr0/din0    : registered macro pins
//   dout0                          : macro read data
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | sweep-writing INIT_VALUE to every word; requests refused
// RUN   | normal operation; requests issued one per cycle
module sky130_sram_port0_ctrl
  import sky130_sram_ctrl_pkg::*;
#(
  parameter int                    NUM_WMASKS    = 4,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 9,
  parameter int                    RSP_DEPTH     = 4,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int                 CW          = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW:0]        RSP_DEPTH_L = (CW + 1)'(RSP_DEPTH);
  localparam ctrl_state_e        RESET_STATE = INIT_ON_RESET ? INIT : RUN;

  if (!lanes_match(NUM_WMASKS, DATA_WIDTH)) begin : g_bad_lanes
    $error("DATA_WIDTH must equal 8*NUM_WMASKS");
  end
  if ((RSP_DEPTH < 2) || ((RSP_DEPTH & (RSP_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("RSP_DEPTH must be a power of 2 and at least 2");
  end

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [1:0]            rd_pipe;
  logic                  accept;
  logic                  accept_rd;
  logic                  credit_ok;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credits_used;

  // Every read in the pipe already owns a FIFO slot, so admitting a read only
  // when stored + in-flight is below depth makes overflow impossible.
  assign credits_used = {1'b0, fifo_count}
                      + {{CW{1'b0}}, rd_pipe[0]}
                      + {{CW{1'b0}}, rd_pipe[1]};
  assign credit_ok    = (credits_used < RSP_DEPTH_L);

  // init_done trails the INIT->RUN transition by one cycle, so it also gates
  // acceptance: nothing is issued while the last sweep write is on the pins.
  assign req_ready = init_done && (req_we || credit_ok);
  assign accept    = req_valid && req_ready;
  assign accept_rd = accept && !req_we;

  assign fifo_pop  = rsp_ready && !fifo_empty;
  assign rsp_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      init_addr <= '0;
      init_done <= 1'b0;
      rd_pipe   <= 2'b00;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
    end else begin
      init_done <= (state == RUN);
      rd_pipe   <= {rd_pipe[0], accept_rd};
      if (state == INIT) begin
        csb0      <= 1'b0;
        web0      <= 1'b0;
        wmask0    <= '1;
        addr0     <= init_addr;
        din0      <= INIT_VALUE;
        init_addr <= init_addr + 1'b1;
        if (init_addr == {ADDR_WIDTH{1'b1}}) begin
          state <= RUN;
        end
      end else if (accept) begin
        csb0  <= 1'b0;
        web0  <= ~req_we;
        addr0 <= req_addr;
        if (req_we) begin
          wmask0 <= req_wmask;
          din0   <= req_wdata;
        end else begin
          wmask0 <= '0;
        end
      end else begin
        csb0 <= 1'b1;
      end
    end
  end

  // rd_pipe[1] marks the edge two cycles after a read accept, when the
  // macro's dout0 for that read is stable.
  sky130_sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pipe[1]),
    .push_data (dout0),
    .pop       (fifo_pop),
    .pop_data  (rsp_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
